// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolution stage: MIPS opcode/function
// constants, REGIMM selectors and the 2-bit saturating counter type.
package branch_resolve_unit_pkg;

   // Primary opcodes
   localparam logic [5:0] OPC_SPECIAL = 6'b000000;
   localparam logic [5:0] OPC_REGIMM  = 6'b000001;
   localparam logic [5:0] OPC_J       = 6'b000010;
   localparam logic [5:0] OPC_JAL     = 6'b000011;
   localparam logic [5:0] OPC_BEQ     = 6'b000100;
   localparam logic [5:0] OPC_BNE     = 6'b000101;
   localparam logic [5:0] OPC_BLEZ    = 6'b000110;
   localparam logic [5:0] OPC_BGTZ    = 6'b000111;

   // SPECIAL function codes
   localparam logic [5:0] FNC_JR      = 6'b001000;
   localparam logic [5:0] FNC_JALR    = 6'b001001;
   localparam logic [5:0] FNC_TEQ     = 6'b110100;

   // REGIMM rt selectors
   localparam logic [4:0] RT_BLTZ     = 5'b00000;
   localparam logic [4:0] RT_BGEZ     = 5'b00001;

   // 2-bit saturating predictor counter; MSB is the prediction
   typedef enum logic [1:0] {
      CNT_SNT = 2'b00,
      CNT_WNT = 2'b01,
      CNT_WT  = 2'b10,
      CNT_ST  = 2'b11
   } bht_cnt_e;

   localparam bht_cnt_e CNT_RESET = CNT_WNT;

   // Saturating step toward taken / not-taken
   function automatic bht_cnt_e cnt_next(input bht_cnt_e cur, input logic taken);
      bht_cnt_e nxt;
      nxt = cur;
      if (taken && (cur != CNT_ST)) begin
         nxt = bht_cnt_e'(cur + 2'd1);
      end else if (!taken && (cur != CNT_SNT)) begin
         nxt = bht_cnt_e'(cur - 2'd1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bru_bht.sv
// Branch history table: array of 2-bit saturating counters with one
// combinational read port (fetch lookup) and one registered update port.
// A read of the entry being written in the same cycle returns the old value.
module bru_bht
   import branch_resolve_unit_pkg::*;
#(
   parameter int BHT_DEPTH = 64,
   parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic             rd_taken_o,
   input  logic             upd_en_i,
   input  logic [IDX_W-1:0] upd_idx_i,
   input  logic             upd_taken_i
);

   bht_cnt_e cnt_q [BHT_DEPTH];
   bht_cnt_e cnt_d;

   // Next value of the entry addressed by the update port
   assign cnt_d = cnt_next(cnt_q[upd_idx_i], upd_taken_i);

   // Counter storage: all entries start weak-not-taken
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < BHT_DEPTH; i++) begin
            cnt_q[i] <= CNT_RESET;
         end
      end else if (upd_en_i) begin
         cnt_q[upd_idx_i] <= cnt_d;
      end
   end

   assign rd_taken_o = cnt_q[rd_idx_i][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: decodes branch/jump/trap/exception conditions,
// registers the outcome, flags mispredicts and trains the predictor table.
// Optional feature macro: BRU_BHT_EN (counter table present); when undefined
// the fetch prediction is statically not-taken.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BHT_DEPTH = 64,
   parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
   input  logic            clk_in,
   input  logic            rst_n_in,
   input  logic            in_valid,
   input  logic            stall_in,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] val_a,
   input  logic [XLEN-1:0] val_b,
   input  logic [5:0]      opcode,
   input  logic [5:0]      func_code,
   input  logic [4:0]      rt_code,
   input  logic            exc_flag,
   input  logic            in_pred_taken,
   input  logic [XLEN-1:0] fetch_pc,
   output logic            fetch_pred_taken,
   output logic            res_valid,
   output logic            res_taken,
   output logic            res_mispredict,
   output logic            flush_req,
   output logic [15:0]     mispredict_cnt
);

   logic signed [XLEN-1:0] a_s;
   logic signed [XLEN-1:0] b_s;
   logic                   a_neg;
   logic                   a_zero;
   logic                   is_known;
   logic                   is_cond;
   logic                   taken_d;
   logic                   mispredict_d;
   logic                   res_valid_q;
   logic                   res_taken_q;
   logic                   res_mispredict_q;
   logic                   flush_req_q;
   logic [15:0]            mispredict_cnt_q;
   logic                   unused_bits;

   assign a_s    = signed'(val_a);
   assign b_s    = signed'(val_b);
   assign a_neg  = a_s[XLEN-1];
   assign a_zero = (a_s == b_s - b_s);

   // Condition decode: recognised encodings win over exc_flag
   always_comb begin
      taken_d  = 1'b0;
      is_known = 1'b1;
      is_cond  = 1'b0;
      case (opcode)
         OPC_BEQ: begin
            is_cond = 1'b1;
            taken_d = (a_s == b_s);
         end
         OPC_BNE: begin
            is_cond = 1'b1;
            taken_d = (a_s != b_s);
         end
         OPC_REGIMM: begin
            if (rt_code == RT_BGEZ) begin
               is_cond = 1'b1;
               taken_d = !a_neg;
            end else if (rt_code == RT_BLTZ) begin
               is_cond = 1'b1;
               taken_d = a_neg;
            end else begin
               is_known = 1'b0;
            end
         end
         OPC_BGTZ: begin
            is_cond = 1'b1;
            taken_d = !a_neg && !a_zero;
         end
         OPC_BLEZ: begin
            is_cond = 1'b1;
            taken_d = a_neg || a_zero;
         end
         OPC_J, OPC_JAL: taken_d = 1'b1;
         OPC_SPECIAL: begin
            case (func_code)
               FNC_JR, FNC_JALR: taken_d = 1'b1;
               FNC_TEQ:          taken_d = (a_s == b_s);
               default:          is_known = 1'b0;
            endcase
         end
         default: is_known = 1'b0;
      endcase
      if (!is_known) begin
         taken_d = exc_flag;
      end
   end

   assign mispredict_d = taken_d ^ in_pred_taken;

   // Result registers and saturating mispredict counter; stall freezes all
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         res_valid_q      <= 1'b0;
         res_taken_q      <= 1'b0;
         res_mispredict_q <= 1'b0;
         flush_req_q      <= 1'b0;
         mispredict_cnt_q <= 16'd0;
      end else if (!stall_in) begin
         res_valid_q      <= in_valid;
         res_taken_q      <= in_valid & taken_d;
         res_mispredict_q <= in_valid & mispredict_d;
         flush_req_q      <= in_valid & mispredict_d;
         if (in_valid && mispredict_d && (mispredict_cnt_q != 16'hFFFF)) begin
            mispredict_cnt_q <= mispredict_cnt_q + 16'd1;
         end
      end
   end

   assign res_valid      = res_valid_q;
   assign res_taken      = res_taken_q;
   assign res_mispredict = res_mispredict_q;
   assign flush_req      = flush_req_q;
   assign mispredict_cnt = mispredict_cnt_q;

`ifdef BRU_BHT_EN
   bru_bht #(
      .BHT_DEPTH (BHT_DEPTH),
      .IDX_W     (IDX_W)
   ) u_bht (
      .clk_i       (clk_in),
      .rst_n_i     (rst_n_in),
      .rd_idx_i    (fetch_pc[IDX_W+1:2]),
      .rd_taken_o  (fetch_pred_taken),
      .upd_en_i    (in_valid & ~stall_in & is_cond),
      .upd_idx_i   (in_pc[IDX_W+1:2]),
      .upd_taken_i (taken_d)
   );
`else
   assign fetch_pred_taken = 1'b0;
`endif

   // PC bits outside the index field do not affect the result
   assign unused_bits = ^{in_pc, fetch_pc, is_cond};

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; expected fetch predictions follow
// BRU_BHT_EN (static not-taken when undefined).
module tb_branch_resolve_unit;
   import branch_resolve_unit_pkg::*;

`ifdef BRU_BHT_EN
   localparam logic BHT = 1'b1;
`else
   localparam logic BHT = 1'b0;
`endif

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        in_valid;
   logic        stall_in;
   logic [31:0] in_pc;
   logic [31:0] val_a;
   logic [31:0] val_b;
   logic [5:0]  opcode;
   logic [5:0]  func_code;
   logic [4:0]  rt_code;
   logic        exc_flag;
   logic        in_pred_taken;
   logic [31:0] fetch_pc;
   logic        fetch_pred_taken;
   logic        res_valid;
   logic        res_taken;
   logic        res_mispredict;
   logic        flush_req;
   logic [15:0] mispredict_cnt;

   int vec_cnt = 0;
   int err_cnt = 0;

   branch_resolve_unit #(.XLEN(32), .BHT_DEPTH(64)) dut (
      .clk_in           (clk_in),
      .rst_n_in         (rst_n_in),
      .in_valid         (in_valid),
      .stall_in         (stall_in),
      .in_pc            (in_pc),
      .val_a            (val_a),
      .val_b            (val_b),
      .opcode           (opcode),
      .func_code        (func_code),
      .rt_code          (rt_code),
      .exc_flag         (exc_flag),
      .in_pred_taken    (in_pred_taken),
      .fetch_pc         (fetch_pc),
      .fetch_pred_taken (fetch_pred_taken),
      .res_valid        (res_valid),
      .res_taken        (res_taken),
      .res_mispredict   (res_mispredict),
      .flush_req        (flush_req),
      .mispredict_cnt   (mispredict_cnt)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one instruction, then sample 1ns after the capturing edge
   task automatic issue(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                        input logic pred, input logic exc);
      in_valid      = 1'b1;
      opcode        = op;
      func_code     = fn;
      rt_code       = rt;
      val_a         = a;
      val_b         = b;
      in_pc         = pc;
      in_pred_taken = pred;
      exc_flag      = exc;
      @(posedge clk_in);
      #1;
   endtask

   task automatic expect_res(input string tag, input logic v, input logic t,
                             input logic m, input logic [15:0] c);
      chk({tag, ".valid"}, {31'd0, res_valid}, {31'd0, v});
      chk({tag, ".taken"}, {31'd0, res_taken}, {31'd0, t});
      chk({tag, ".mis"},   {31'd0, res_mispredict}, {31'd0, m});
      chk({tag, ".flush"}, {31'd0, flush_req}, {31'd0, v & m});
      chk({tag, ".cnt"},   {16'd0, mispredict_cnt}, {16'd0, c});
   endtask

   initial begin
      rst_n_in = 1'b0; in_valid = 1'b0; stall_in = 1'b0;
      in_pc = '0; val_a = '0; val_b = '0; opcode = 6'h3F; func_code = '0;
      rt_code = '0; exc_flag = 1'b0; in_pred_taken = 1'b0; fetch_pc = 32'h100;
      repeat (3) @(posedge clk_in);
      #1;
      expect_res("rst", 1'b0, 1'b0, 1'b0, 16'd0);
      chk("rst.fpred100", {31'd0, fetch_pred_taken}, 32'd0);
      fetch_pc = 32'h204; #1;
      chk("rst.fpred204", {31'd0, fetch_pred_taken}, 32'd0);
      rst_n_in = 1'b1;
      @(posedge clk_in); #1;
      expect_res("idle0", 1'b0, 1'b0, 1'b0, 16'd0);

      issue(OPC_BEQ, 6'd0, 5'd0, 32'd5, 32'd5, 32'h204, 1'b0, 1'b0);
      expect_res("beq_eq", 1'b1, 1'b1, 1'b1, 16'd1);
      in_valid = 1'b0;
      @(posedge clk_in); #1;
      expect_res("idle1", 1'b0, 1'b0, 1'b0, 16'd1);

      issue(OPC_REGIMM, 6'd0, RT_BGEZ, 32'hFFFF_FFFF, 32'd0, 32'h308, 1'b0, 1'b0);
      expect_res("bgez_neg", 1'b1, 1'b0, 1'b0, 16'd1);
      issue(OPC_REGIMM, 6'd0, RT_BGEZ, 32'd0, 32'd0, 32'h308, 1'b1, 1'b0);
      expect_res("bgez_zero", 1'b1, 1'b1, 1'b0, 16'd1);
      issue(OPC_BLEZ, 6'd0, 5'd0, 32'd0, 32'd0, 32'h30C, 1'b0, 1'b0);
      expect_res("blez_zero", 1'b1, 1'b1, 1'b1, 16'd2);
      issue(OPC_BGTZ, 6'd0, 5'd0, 32'd0, 32'd0, 32'h310, 1'b0, 1'b0);
      expect_res("bgtz_zero", 1'b1, 1'b0, 1'b0, 16'd2);
      issue(OPC_REGIMM, 6'd0, RT_BLTZ, 32'h8000_0000, 32'd0, 32'h314, 1'b1, 1'b0);
      expect_res("bltz_min", 1'b1, 1'b1, 1'b0, 16'd2);

      fetch_pc = 32'h100;
      for (int i = 0; i < 3; i++) begin
         issue(OPC_BNE, 6'd0, 5'd0, 32'd1, 32'd2, 32'h100, 1'b0, 1'b0);
      end
      expect_res("bne_train", 1'b1, 1'b1, 1'b1, 16'd5);
      chk("train.fpred", {31'd0, fetch_pred_taken}, {31'd0, BHT});

      // Not-taken BNE on the trained index: fetch sees the old counter first
      in_valid = 1'b1; opcode = OPC_BNE; val_a = 32'd7; val_b = 32'd7;
      in_pc = 32'h100; in_pred_taken = 1'b1; exc_flag = 1'b0;
      #1;
      chk("rbw.fpred", {31'd0, fetch_pred_taken}, {31'd0, BHT});
      @(posedge clk_in); #1;
      expect_res("bne_nt1", 1'b1, 1'b0, 1'b1, 16'd6);
      chk("nt1.fpred", {31'd0, fetch_pred_taken}, {31'd0, BHT});
      issue(OPC_BNE, 6'd0, 5'd0, 32'd7, 32'd7, 32'h100, 1'b1, 1'b0);
      expect_res("bne_nt2", 1'b1, 1'b0, 1'b1, 16'd7);
      chk("nt2.fpred", {31'd0, fetch_pred_taken}, 32'd0);

      stall_in = 1'b1;
      issue(OPC_BEQ, 6'd0, 5'd0, 32'd9, 32'd9, 32'h100, 1'b0, 1'b0);
      expect_res("stall", 1'b1, 1'b0, 1'b1, 16'd7);
      chk("stall.fpred", {31'd0, fetch_pred_taken}, 32'd0);
      stall_in = 1'b0;

      issue(6'h3F, 6'd0, 5'd0, 32'd0, 32'd0, 32'h100, 1'b0, 1'b1);
      expect_res("exc", 1'b1, 1'b1, 1'b1, 16'd8);
      chk("exc.fpred", {31'd0, fetch_pred_taken}, 32'd0);
      issue(OPC_BEQ, 6'd0, 5'd0, 32'd1, 32'd2, 32'h418, 1'b1, 1'b1);
      expect_res("beq_exc_prio", 1'b1, 1'b0, 1'b1, 16'd9);
      issue(OPC_J, 6'd0, 5'd0, 32'd0, 32'd0, 32'h500, 1'b1, 1'b0);
      expect_res("j", 1'b1, 1'b1, 1'b0, 16'd9);
      issue(OPC_SPECIAL, FNC_JR, 5'd0, 32'd0, 32'd0, 32'h504, 1'b1, 1'b0);
      expect_res("jr", 1'b1, 1'b1, 1'b0, 16'd9);
      issue(OPC_SPECIAL, FNC_JALR, 5'd0, 32'd0, 32'd0, 32'h508, 1'b0, 1'b0);
      expect_res("jalr", 1'b1, 1'b1, 1'b1, 16'd10);
      issue(OPC_SPECIAL, FNC_TEQ, 5'd0, 32'd3, 32'd4, 32'h50C, 1'b0, 1'b0);
      expect_res("teq_ne", 1'b1, 1'b0, 1'b0, 16'd10);
      issue(OPC_SPECIAL, FNC_TEQ, 5'd0, 32'd6, 32'd6, 32'h510, 1'b1, 1'b0);
      expect_res("teq_eq", 1'b1, 1'b1, 1'b0, 16'd10);
      issue(OPC_SPECIAL, 6'h20, 5'd0, 32'd6, 32'd6, 32'h514, 1'b1, 1'b0);
      expect_res("add", 1'b1, 1'b0, 1'b1, 16'd11);

      fetch_pc = 32'h204;
      issue(OPC_BEQ, 6'd0, 5'd0, 32'd5, 32'd5, 32'h204, 1'b0, 1'b0);
      expect_res("beq_pre_rst", 1'b1, 1'b1, 1'b1, 16'd12);
      chk("pre_rst.fpred", {31'd0, fetch_pred_taken}, {31'd0, BHT});
      rst_n_in = 1'b0;
      #1;
      expect_res("mid_rst", 1'b0, 1'b0, 1'b0, 16'd0);
      chk("mid_rst.fpred", {31'd0, fetch_pred_taken}, 32'd0);
      in_valid = 1'b0;
      @(negedge clk_in);
      rst_n_in = 1'b1;
      @(posedge clk_in); #1;
      expect_res("post_rst", 1'b0, 1'b0, 1'b0, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
